fwd_hazard_unit: RTL and testbench

- Parametrised successor to the two-stage forwarding unit.
- Generalises operand-forwarding selection to NUM_STAGES downstream write-back stages, with youngest-stage priority.
- Adds a sequential load-use hazard controller: a stall FSM with a latency counter that inserts LOAD_LATENCY bubbles.
- Sits between the ID/EX pipeline register and the ALU operand muxes; drives PC/IF-ID hold and ID/EX flush.

---
 rtl/fwd_hazard_pkg.sv | 38 +++
 rtl/fwd_hazard_unit_if.sv | 37 +++
 rtl/fwd_hazard_fsm.sv | 78 +++++++
 rtl/fwd_hazard_unit.sv | 58 +++++
 tb/tb_fwd_hazard_unit.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_pkg.sv
// Shared types and the per-operand forwarding priority encoder for fwd_hazard_unit.
package fwd_hazard_pkg;

  typedef enum logic [0:0] {IDLE, STALL} fsm_state_t;

  localparam int unsigned FWD_SEL_RF    = 0;
  // Upper bounds the encoder is written against; instances must stay within them.
  localparam int unsigned MAX_STAGES    = 15;
  localparam int unsigned MAX_ADDR_W    = 8;
  localparam int unsigned FWD_SEL_MAX_W = 4;

  typedef struct packed {
    logic [FWD_SEL_MAX_W-1:0] sel;
    logic                     unavail;
  } fwd_pick_t;

  // First writing stage with a non-zero matching rd wins; if its data is not
  // ready the operand falls back to the register file and reports unavail.
  function automatic fwd_pick_t fwd_pick(input logic [MAX_STAGES-1:0][MAX_ADDR_W-1:0] rd,
                                         input logic [MAX_STAGES-1:0]                 wr,
                                         input logic [MAX_STAGES-1:0]                 valid,
                                         input logic [MAX_ADDR_W-1:0]                 src);
    fwd_pick_t r;
    logic      found;
    r       = '0;
    r.sel   = FWD_SEL_MAX_W'(FWD_SEL_RF);
    found   = 1'b0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (!found && wr[i] && (rd[i] != '0) && (rd[i] == src)) begin
        found = 1'b1;
        if (valid[i]) r.sel = FWD_SEL_MAX_W'(i + 1);
        else          r.unavail = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle of fwd_hazard_unit: stage sources, EX/ID operands, control outputs.
interface fwd_hazard_unit_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
);
  logic [NUM_STAGES*REG_ADDR_W-1:0] stage_rd;
  logic [NUM_STAGES-1:0]            stage_reg_write;
  logic [NUM_STAGES-1:0]            stage_data_valid;
  logic [REG_ADDR_W-1:0]            id_ex_rs;
  logic [REG_ADDR_W-1:0]            id_ex_rt;
  logic [REG_ADDR_W-1:0]            if_id_rs;
  logic [REG_ADDR_W-1:0]            if_id_rt;
  logic                             id_ex_mem_read;
  logic                             id_ex_reg_write;
  logic [REG_ADDR_W-1:0]            id_ex_rd;
  logic                             ext_hold;
  logic [SEL_W-1:0]                 fw_a_src;
  logic [SEL_W-1:0]                 fw_b_src;
  logic                             fwd_unavail;
  logic                             stall;
  logic                             flush_id_ex;
  logic [31:0]                      perf_stall_cycles;
  logic [15:0]                      perf_load_use;

  modport master (
    output stage_rd, stage_reg_write, stage_data_valid, id_ex_rs, id_ex_rt, if_id_rs, if_id_rt,
           id_ex_mem_read, id_ex_reg_write, id_ex_rd, ext_hold,
    input  fw_a_src, fw_b_src, fwd_unavail, stall, flush_id_ex, perf_stall_cycles, perf_load_use
  );

  modport slave (
    input  stage_rd, stage_reg_write, stage_data_valid, id_ex_rs, id_ex_rt, if_id_rs, if_id_rt,
           id_ex_mem_read, id_ex_reg_write, id_ex_rd, ext_hold,
    output fw_a_src, fw_b_src, fwd_unavail, stall, flush_id_ex, perf_stall_cycles, perf_load_use
  );
endinterface

// File: rtl/fwd_hazard_fsm.sv
// Load-use stall controller: IDLE/STALL with a bubble counter; optional perf counters
// are built only when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_fsm
  import fwd_hazard_pkg::*;
#(
  parameter int unsigned LOAD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_hz,
  input  logic        ext_hold,
  output logic        stall_o,
  output logic        flush_id_ex_o,
  output logic [31:0] perf_stall_cycles_o,
  output logic [15:0] perf_load_use_o
);

  localparam logic [3:0] CntInit = 4'(LOAD_LATENCY - 1);

  fsm_state_t state_q;
  logic [3:0] cnt_q;
  logic       stall_raw;
  logic       hz_commit;

  // The first bubble is issued combinationally from IDLE; STALL covers the rest.
  assign stall_raw     = (state_q == STALL) | ld_hz;
  assign hz_commit     = (state_q == IDLE) & ld_hz & ~ext_hold;
  assign stall_o       = ~rst & stall_raw;
  assign flush_id_ex_o = ~rst & stall_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hz_commit && (LOAD_LATENCY > 1)) begin
            state_q <= STALL;
            cnt_q   <= CntInit;
          end
        end
        STALL: begin
          if (!ext_hold) begin
            if (cnt_q == 4'd1) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] lu_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      if (stall_raw && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (hz_commit && (lu_cnt_q != '1))    lu_cnt_q    <= lu_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cycles_o = stall_cnt_q;
  assign perf_load_use_o     = lu_cnt_q;
`else
  assign perf_stall_cycles_o = '0;
  assign perf_load_use_o     = '0;
`endif

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select over NUM_STAGES write-back stages plus load-use stall control.
// Perf counters are enabled with FWD_HAZARD_PERF_EN.
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned NUM_STAGES   = 2,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned SEL_W        = $clog2(NUM_STAGES + 1)
) (
  input logic               clk,
  input logic               rst,
  fwd_hazard_unit_if.slave  bus
);

  logic [MAX_STAGES-1:0][MAX_ADDR_W-1:0] rd_arr;
  logic [MAX_STAGES-1:0]                 wr_arr;
  logic [MAX_STAGES-1:0]                 vld_arr;
  fwd_pick_t                             pick_a;
  fwd_pick_t                             pick_b;
  logic                                  ld_hz;

  // Unused encoder slots stay non-writing so they can never match.
  always_comb begin
    rd_arr  = '0;
    wr_arr  = '0;
    vld_arr = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      rd_arr[i]  = MAX_ADDR_W'(bus.stage_rd[i*REG_ADDR_W +: REG_ADDR_W]);
      wr_arr[i]  = bus.stage_reg_write[i];
      vld_arr[i] = bus.stage_data_valid[i];
    end
  end

  assign pick_a = fwd_pick(rd_arr, wr_arr, vld_arr, MAX_ADDR_W'(bus.id_ex_rs));
  assign pick_b = fwd_pick(rd_arr, wr_arr, vld_arr, MAX_ADDR_W'(bus.id_ex_rt));

  assign bus.fw_a_src    = rst ? SEL_W'(FWD_SEL_RF) : SEL_W'(pick_a.sel);
  assign bus.fw_b_src    = rst ? SEL_W'(FWD_SEL_RF) : SEL_W'(pick_b.sel);
  assign bus.fwd_unavail = ~rst & (pick_a.unavail | pick_b.unavail);

  assign ld_hz = bus.id_ex_mem_read & bus.id_ex_reg_write & (bus.id_ex_rd != '0) &
                 ((bus.id_ex_rd == bus.if_id_rs) | (bus.id_ex_rd == bus.if_id_rt));

  fwd_hazard_fsm #(
    .LOAD_LATENCY (LOAD_LATENCY)
  ) u_fsm (
    .clk                 (clk),
    .rst                 (rst),
    .ld_hz               (ld_hz),
    .ext_hold            (bus.ext_hold),
    .stall_o             (bus.stall),
    .flush_id_ex_o       (bus.flush_id_ex),
    .perf_stall_cycles_o (bus.perf_stall_cycles),
    .perf_load_use_o     (bus.perf_load_use)
  );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: a 2-stage/LOAD_LATENCY=3 unit and a 4-stage/6-bit/LOAD_LATENCY=1 unit.
module tb_fwd_hazard_unit;

`ifdef FWD_HAZARD_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       un;
    logic       st;
    logic       fl;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.REG_ADDR_W(5), .NUM_STAGES(2), .SEL_W(2)) a_if ();
  fwd_hazard_unit_if #(.REG_ADDR_W(6), .NUM_STAGES(4), .SEL_W(3)) w_if ();

  fwd_hazard_unit #(
    .REG_ADDR_W   (5),
    .NUM_STAGES   (2),
    .LOAD_LATENCY (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  fwd_hazard_unit #(
    .REG_ADDR_W   (6),
    .NUM_STAGES   (4),
    .LOAD_LATENCY (1)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (w_if.slave)
  );

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic obs_t obs_a();
    return '{a: {1'b0, a_if.fw_a_src}, b: {1'b0, a_if.fw_b_src}, un: a_if.fwd_unavail,
             st: a_if.stall, fl: a_if.flush_id_ex};
  endfunction

  function automatic obs_t obs_w();
    return '{a: w_if.fw_a_src, b: w_if.fw_b_src, un: w_if.fwd_unavail,
             st: w_if.stall, fl: w_if.flush_id_ex};
  endfunction

  task automatic push(input string n, input logic [2:0] a, input logic [2:0] b,
                      input logic un, input logic st, input logic fl);
    sb_t s;
    s.name = n;
    s.exp  = '{a: a, b: b, un: un, st: st, fl: fl};
    sb_q.push_back(s);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_if.stage_rd = '0;  a_if.stage_reg_write = '0;  a_if.stage_data_valid = '1;
    a_if.id_ex_rs = '0;  a_if.id_ex_rt = '0;  a_if.if_id_rs = '0;  a_if.if_id_rt = '0;
    a_if.id_ex_mem_read = 1'b0;  a_if.id_ex_reg_write = 1'b0;  a_if.id_ex_rd = '0;
    a_if.ext_hold = 1'b0;
    w_if.stage_rd = '0;  w_if.stage_reg_write = '0;  w_if.stage_data_valid = '1;
    w_if.id_ex_rs = '0;  w_if.id_ex_rt = '0;  w_if.if_id_rs = '0;  w_if.if_id_rt = '0;
    w_if.id_ex_mem_read = 1'b0;  w_if.id_ex_reg_write = 1'b0;  w_if.id_ex_rd = '0;
    w_if.ext_hold = 1'b0;
  endtask

  // Load into r5 in EX with the ID instruction reading r5 as rt.
  task automatic set_load(input logic on);
    a_if.id_ex_mem_read  = on;
    a_if.id_ex_reg_write = on;
    a_if.id_ex_rd        = 5'd5;
    a_if.if_id_rt        = 5'd5;
  endtask

  task automatic test_reset();
    sb_t  e;
    obs_t got;
    rst = 1'b1;
    a_if.stage_rd = {5'd3, 5'd3};  a_if.stage_reg_write = 2'b11;  a_if.id_ex_rs = 5'd3;
    w_if.stage_rd = {6'd9, 6'd9, 6'd9, 6'd9};  w_if.stage_reg_write = 4'hF;  w_if.id_ex_rt = 6'd9;
    set_load(1'b1);
    next_cycle();
    push("reset_a", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    push("reset_w", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    e = sb_q.pop_front();  got = obs_a();  checks++;
    if (got !== e.exp) begin
      errors++;  $display("FAIL %s: got %b required %b", e.name, got, e.exp);
    end
    e = sb_q.pop_front();  got = obs_w();  checks++;
    if (got !== e.exp) begin
      errors++;  $display("FAIL %s: got %b required %b", e.name, got, e.exp);
    end
    checks++;
    if ((a_if.perf_stall_cycles !== 32'd0) || (a_if.perf_load_use !== 16'd0)) begin
      errors++;
      $display("FAIL reset_perf: got %0d/%0d required 0/0",
               a_if.perf_stall_cycles, a_if.perf_load_use);
    end
    rst = 1'b0;
    clear_inputs();
    next_cycle();
  endtask

  typedef struct {
    logic [4:0] rd1, rd2;
    logic [1:0] wr, vld;
    logic [4:0] rs, rt;
    logic [2:0] a, b;
    logic       un;
  } fvec_t;

  task automatic test_forward();
    fvec_t v[7];
    sb_t   e;
    obs_t  got;
    v[0] = '{5'd3, 5'd3, 2'b11, 2'b11, 5'd3, 5'd0, 3'd1, 3'd0, 1'b0};
    v[1] = '{5'd3, 5'd3, 2'b10, 2'b11, 5'd3, 5'd0, 3'd2, 3'd0, 1'b0};
    v[2] = '{5'd0, 5'd0, 2'b11, 2'b11, 5'd0, 5'd0, 3'd0, 3'd0, 1'b0};
    v[3] = '{5'd7, 5'd7, 2'b11, 2'b10, 5'd0, 5'd7, 3'd0, 3'd0, 1'b1};
    v[4] = '{5'd4, 5'd9, 2'b11, 2'b11, 5'd9, 5'd4, 3'd2, 3'd1, 1'b0};
    v[5] = '{5'd6, 5'd2, 2'b11, 2'b11, 5'd6, 5'd6, 3'd1, 3'd1, 1'b0};
    v[6] = '{5'd8, 5'd8, 2'b00, 2'b11, 5'd8, 5'd8, 3'd0, 3'd0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      a_if.stage_rd         = {v[i].rd2, v[i].rd1};
      a_if.stage_reg_write  = v[i].wr;
      a_if.stage_data_valid = v[i].vld;
      a_if.id_ex_rs         = v[i].rs;
      a_if.id_ex_rt         = v[i].rt;
      push($sformatf("fwd_%0d", i), v[i].a, v[i].b, v[i].un, 1'b0, 1'b0);
      @(negedge clk);
      e = sb_q.pop_front();  got = obs_a();  checks++;
      if (got !== e.exp) begin
        errors++;  $display("FAIL %s: got %b required %b", e.name, got, e.exp);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    logic exp_st[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    sb_t  e;
    obs_t got;
    for (int i = 0; i < 4; i++) begin
      set_load(i == 0);
      push($sformatf("load_use_c%0d", i), 3'd0, 3'd0, 1'b0, exp_st[i], exp_st[i]);
      @(negedge clk);
      e = sb_q.pop_front();  got = obs_a();  checks++;
      if (got !== e.exp) begin
        errors++;  $display("FAIL %s: got %b required %b", e.name, got, e.exp);
      end
      next_cycle();
    end
    checks++;
    if ((a_if.perf_stall_cycles !== (PerfEn ? 32'd3 : 32'd0)) ||
        (a_if.perf_load_use !== (PerfEn ? 16'd1 : 16'd0))) begin
      errors++;
      $display("FAIL load_use_perf: got %0d/%0d", a_if.perf_stall_cycles, a_if.perf_load_use);
    end
  endtask

  task automatic test_hold_in_stall();
    logic ld[6]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic hold[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic st[6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    sb_t  e;
    obs_t got;
    for (int i = 0; i < 6; i++) begin
      set_load(ld[i]);
      a_if.ext_hold = hold[i];
      push($sformatf("hold_stall_c%0d", i), 3'd0, 3'd0, 1'b0, st[i], st[i]);
      @(negedge clk);
      e = sb_q.pop_front();  got = obs_a();  checks++;
      if (got !== e.exp) begin
        errors++;  $display("FAIL %s: got %b required %b", e.name, got, e.exp);
      end
      next_cycle();
    end
    checks++;
    if ((a_if.perf_stall_cycles !== (PerfEn ? 32'd8 : 32'd0)) ||
        (a_if.perf_load_use !== (PerfEn ? 16'd2 : 16'd0))) begin
      errors++;
      $display("FAIL hold_stall_perf: got %0d/%0d", a_if.perf_stall_cycles, a_if.perf_load_use);
    end
  endtask

  // Hazard arrives while frozen: held inputs must not count as extra hazards.
  task automatic test_hold_in_idle();
    logic ld[6]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic hold[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic st[6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    sb_t  e;
    obs_t got;
    for (int i = 0; i < 6; i++) begin
      set_load(ld[i]);
      a_if.ext_hold = hold[i];
      push($sformatf("hold_idle_c%0d", i), 3'd0, 3'd0, 1'b0, st[i], st[i]);
      @(negedge clk);
      e = sb_q.pop_front();  got = obs_a();  checks++;
      if (got !== e.exp) begin
        errors++;  $display("FAIL %s: got %b required %b", e.name, got, e.exp);
      end
      next_cycle();
    end
    checks++;
    if ((a_if.perf_stall_cycles !== (PerfEn ? 32'd13 : 32'd0)) ||
        (a_if.perf_load_use !== (PerfEn ? 16'd3 : 16'd0))) begin
      errors++;
      $display("FAIL hold_idle_perf: got %0d/%0d", a_if.perf_stall_cycles, a_if.perf_load_use);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic ld[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic rs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic st[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    sb_t  e;
    obs_t got;
    for (int i = 0; i < 4; i++) begin
      set_load(ld[i]);
      rst = rs[i];
      push($sformatf("rst_mid_c%0d", i), 3'd0, 3'd0, 1'b0, st[i], st[i]);
      @(negedge clk);
      e = sb_q.pop_front();  got = obs_a();  checks++;
      if (got !== e.exp) begin
        errors++;  $display("FAIL %s: got %b required %b", e.name, got, e.exp);
      end
      next_cycle();
    end
    checks++;
    if ((a_if.perf_stall_cycles !== 32'd0) || (a_if.perf_load_use !== 16'd0)) begin
      errors++;
      $display("FAIL rst_mid_perf: got %0d/%0d required 0/0",
               a_if.perf_stall_cycles, a_if.perf_load_use);
    end
  endtask

  task automatic test_wide();
    sb_t  e;
    obs_t got;
    for (int i = 0; i < 5; i++) begin
      w_if.stage_rd         = {6'd40, 6'd40, 6'd40, 6'd41};
      w_if.stage_reg_write  = (i == 1) ? 4'b1001 : 4'b1011;
      w_if.stage_data_valid = (i == 2) ? 4'b1101 : 4'b1111;
      w_if.id_ex_rs         = 6'd40;
      w_if.id_ex_rt         = 6'd41;
      w_if.id_ex_mem_read   = (i == 3);
      w_if.id_ex_reg_write  = (i == 3);
      w_if.id_ex_rd         = 6'd33;
      w_if.if_id_rs         = 6'd33;
      unique case (i)
        0:       push("wide_prio",    3'd2, 3'd1, 1'b0, 1'b0, 1'b0);
        1:       push("wide_skip",    3'd4, 3'd1, 1'b0, 1'b0, 1'b0);
        2:       push("wide_unavail", 3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
        3:       push("wide_ll1_hz",  3'd2, 3'd1, 1'b0, 1'b1, 1'b1);
        default: push("wide_ll1_end", 3'd2, 3'd1, 1'b0, 1'b0, 1'b0);
      endcase
      @(negedge clk);
      e = sb_q.pop_front();  got = obs_w();  checks++;
      if (got !== e.exp) begin
        errors++;  $display("FAIL %s: got %b required %b", e.name, got, e.exp);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_hold_in_stall();
    test_hold_in_idle();
    test_reset_mid_stall();
    test_wide();
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
